// File: rtl/i2s_rx_bus_interface.sv
// rtl/i2s_rx_bus_interface.sv - I2S receiver with 16-bit stereo frame FIFO and bus register slave
// Codec is bit-clock master; all capture logic runs on i_Clk using oversampled SCLK edges.
module i2s_rx_bus_interface #(
    parameter int ADDR_SEL_BITS = 4,
    parameter int FIFO_DEPTH    = 16
) (
    input  logic                      i_Clk,
    input  logic                      i_Reset,
    input  logic                      i_SlaveSel,
    input  logic [30-ADDR_SEL_BITS-1:0] i_RegAddr,
    input  logic [3:0]                i_AV_ByteEn,
    input  logic                      i_AV_Read,
    input  logic                      i_AV_Write,
    output logic [31:0]               o_AV_ReadData,
    input  logic [31:0]               i_AV_WriteData,
    output logic                      o_AV_WaitRequest,
    input  logic                      i_I2S0_SDOUT,
    input  logic                      i_I2S0_SCLK,
    input  logic                      i_I2S0_LRCK
);

    localparam int RA = 30 - ADDR_SEL_BITS;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, SYNC, RUN} state_t;

    logic [1:0]  sd_sync, sclk_sync, lr_sync;
    logic        sclk_prev;
    logic        sclk_rise, sd_bit, lr_bit;
    logic        lr_prev, lr_change, frame_edge;

    state_t      state;
    logic [4:0]  cnt, cnt_eff;
    logic        cnt_clr, room;
    logic [3:0]  bit_idx;
    logic [15:0] left_q, right_q;
    logic        push_pend;

    logic        en, ovr;
    logic [31:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic        full, empty;
    logic        sel_data, sel_cntrl, rd_data, pop, wr_cntrl, flush;
    logic        do_push, overflow;
    logic [31:0] cntrl_word;
    logic        unused_bits;

    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            sd_sync   <= '0;
            sclk_sync <= '0;
            lr_sync   <= '0;
            sclk_prev <= 1'b0;
        end else begin
            sd_sync   <= {sd_sync[0], i_I2S0_SDOUT};
            sclk_sync <= {sclk_sync[0], i_I2S0_SCLK};
            lr_sync   <= {lr_sync[0], i_I2S0_LRCK};
            sclk_prev <= sclk_sync[1];
        end
    end

    assign sclk_rise  = sclk_sync[1] & ~sclk_prev;
    assign sd_bit     = sd_sync[1];
    assign lr_bit     = lr_sync[1];
    assign lr_change  = sclk_rise & (lr_bit != lr_prev);
    assign frame_edge = sclk_rise & lr_prev & ~lr_bit;

    // The count restarts on the edge following a channel change, so the
    // transition edge itself still lands the outgoing channel's LSB.
    assign cnt_eff = cnt_clr ? 5'd0 : cnt;
    assign room    = cnt_eff < 5'd16;
    assign bit_idx = 4'd15 - cnt_eff[3:0];

    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            state     <= IDLE;
            cnt       <= '0;
            cnt_clr   <= 1'b0;
            left_q    <= '0;
            right_q   <= '0;
            lr_prev   <= 1'b0;
            push_pend <= 1'b0;
        end else begin
            push_pend <= 1'b0;
            if (sclk_rise)
                lr_prev <= lr_bit;
            if (!en) begin
                state   <= IDLE;
                cnt     <= '0;
                cnt_clr <= 1'b0;
                left_q  <= '0;
                right_q <= '0;
            end else begin
                if (sclk_rise) begin
                    cnt     <= room ? cnt_eff + 5'd1 : cnt_eff;
                    cnt_clr <= lr_change;
                end
                case (state)
                    IDLE: state <= SYNC;
                    SYNC: begin
                        if (frame_edge)
                            state <= RUN;
                    end
                    RUN: begin
                        if (push_pend) begin
                            left_q  <= '0;
                            right_q <= '0;
                        end
                        if (sclk_rise && room) begin
                            if (lr_prev)
                                right_q[bit_idx] <= sd_bit;
                            else
                                left_q[bit_idx] <= sd_bit;
                        end
                        if (frame_edge)
                            push_pend <= 1'b1;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign sel_data  = i_SlaveSel && (i_RegAddr == RA'(0));
    assign sel_cntrl = i_SlaveSel && (i_RegAddr == RA'(1));
    assign rd_data   = sel_data & i_AV_Read;
    assign pop       = rd_data & ~empty;
    assign wr_cntrl  = sel_cntrl & i_AV_Write & i_AV_ByteEn[0];
    assign flush     = wr_cntrl & i_AV_WriteData[4];

    assign full     = (count == CW'(FIFO_DEPTH));
    assign empty    = (count == '0);
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the frame.
    assign do_push  = push_pend & (~full | pop) & ~flush;
    assign overflow = push_pend & full & ~pop & ~flush;

    always_ff @(posedge i_Clk) begin
        if (do_push)
            mem[wr_ptr] <= {left_q, right_q};
    end

    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_comb begin
        cntrl_word          = '0;
        cntrl_word[0]       = full;
        cntrl_word[1]       = empty;
        cntrl_word[2]       = ovr;
        cntrl_word[3]       = en;
        cntrl_word[4 +: CW] = count;
    end

    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            en            <= 1'b0;
            ovr           <= 1'b0;
            o_AV_ReadData <= '0;
        end else begin
            if (wr_cntrl)
                en <= i_AV_WriteData[3];
            if (overflow)
                ovr <= 1'b1;
            else if (wr_cntrl && i_AV_WriteData[2])
                ovr <= 1'b0;
            if (i_SlaveSel && i_AV_Read) begin
                if (sel_data)
                    o_AV_ReadData <= empty ? 32'd0 : mem[rd_ptr];
                else if (sel_cntrl)
                    o_AV_ReadData <= cntrl_word;
                else
                    o_AV_ReadData <= 32'd0;
            end
        end
    end

    assign o_AV_WaitRequest = 1'b0;

    assign unused_bits = ^{i_AV_ByteEn[3:1], i_AV_WriteData[31:5], i_AV_WriteData[1:0]};

endmodule

// File: tb/tb_i2s_rx_bus_interface.sv
// tb/tb_i2s_rx_bus_interface.sv - directed self-checking bench for i2s_rx_bus_interface
`timescale 1ns/1ps
module tb_i2s_rx_bus_interface;

    logic        clk = 1'b0;
    logic        rst;
    logic        sel, rd, wr;
    logic [25:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata, rdata;
    logic        wait_req;
    logic        sd, sclk, lrck;

    int   errors = 0;
    int   checks = 0;
    logic carry;
    bit   closed;
    logic [31:0] d;

    i2s_rx_bus_interface #(.ADDR_SEL_BITS(4), .FIFO_DEPTH(16)) dut (
        .i_Clk            (clk),
        .i_Reset          (rst),
        .i_SlaveSel       (sel),
        .i_RegAddr        (addr),
        .i_AV_ByteEn      (be),
        .i_AV_Read        (rd),
        .i_AV_Write       (wr),
        .o_AV_ReadData    (rdata),
        .i_AV_WriteData   (wdata),
        .o_AV_WaitRequest (wait_req),
        .i_I2S0_SDOUT     (sd),
        .i_I2S0_SCLK      (sclk),
        .i_I2S0_LRCK      (lrck)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic bus_write(input logic [25:0] a, input logic [31:0] dat, input logic [3:0] b);
        @(negedge clk);
        sel = 1'b1; wr = 1'b1; addr = a; wdata = dat; be = b;
        @(negedge clk);
        sel = 1'b0; wr = 1'b0; be = 4'h0;
    endtask

    task automatic bus_read(input logic [25:0] a, output logic [31:0] dat);
        @(negedge clk);
        sel = 1'b1; rd = 1'b1; addr = a;
        @(negedge clk);
        sel = 1'b0; rd = 1'b0;
        dat = rdata;
    endtask

    // One SCLK period of 8 system clocks; data and LRCK change while SCLK is low.
    task automatic send_bit(input logic lr, input logic b);
        @(negedge clk);
        sclk = 1'b0; lrck = lr; sd = b;
        repeat (3) @(negedge clk);
        @(negedge clk);
        sclk = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    function automatic logic chan_bit(input logic [15:0] w, input logic fill, input int j);
        if (j < 16)
            return w[15-j];
        return fill;
    endfunction

    // I2S framing: each channel's bits are delayed one SCLK behind LRCK.
    task automatic send_frame(input logic [15:0] l, input logic [15:0] r, input int n,
                              input logic fl, input logic fr);
        for (int j = (closed ? 1 : 0); j < n; j++)
            send_bit(1'b0, (j == 0) ? carry : chan_bit(l, fl, j - 1));
        carry = chan_bit(l, fl, n - 1);
        for (int j = 0; j < n; j++)
            send_bit(1'b1, (j == 0) ? carry : chan_bit(r, fr, j - 1));
        carry = chan_bit(r, fr, n - 1);
        closed = 1'b0;
    endtask

    task automatic close_frame();
        send_bit(1'b0, carry);
        closed = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    // Issues a DATA read on exactly the cycle the closing edge pushes its frame.
    task automatic close_with_read(output logic [31:0] dat);
        @(negedge clk);
        sclk = 1'b0; lrck = 1'b0; sd = carry;
        repeat (3) @(negedge clk);
        @(negedge clk);
        sclk = 1'b1;
        repeat (2) @(negedge clk);
        @(negedge clk);
        sel = 1'b1; rd = 1'b1; addr = 26'd0;
        @(negedge clk);
        sel = 1'b0; rd = 1'b0;
        dat = rdata;
        closed = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic left_partial(input int k);
        for (int j = 0; j < k; j++)
            send_bit(1'b0, 1'b1);
        carry = 1'b1;
    endtask

    task automatic right_partial(input int k);
        for (int j = 0; j < k; j++)
            send_bit(1'b1, 1'b1);
        carry = 1'b1;
        closed = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; sel = 1'b0; rd = 1'b0; wr = 1'b0; addr = '0; be = '0; wdata = '0;
        sd = 1'b0; sclk = 1'b0; lrck = 1'b0;
        carry = 1'b0; closed = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_rdata", rdata, 32'h0);
        check("waitrequest", {31'd0, wait_req}, 32'h0);
        rst = 1'b0;
        bus_read(26'd1, d); check("reset_cntrl", d, 32'h0000_0002);

        // Basic capture: first frame after enable only synchronises.
        bus_write(26'd1, 32'h08, 4'h1);
        bus_read(26'd1, d); check("enable_cntrl", d, 32'h0000_000A);
        send_frame(16'hFFFF, 16'hFFFF, 16, 1'b0, 1'b0);
        send_frame(16'hA5C3, 16'h1234, 16, 1'b0, 1'b0);
        close_frame();
        bus_read(26'd1, d); check("one_entry_cntrl", d, 32'h0000_0018);
        bus_read(26'd0, d); check("frame_a5c3", d, 32'hA5C3_1234);
        bus_read(26'd1, d); check("after_pop_cntrl", d, 32'h0000_000A);

        // 32 SCLKs per channel: only the first 16 bits of each channel are kept.
        send_frame(16'hBEEF, 16'h0001, 32, 1'b1, 1'b0);
        close_frame();
        bus_read(26'd0, d); check("frame_32bit", d, 32'hBEEF_0001);

        // Register access corner cases.
        bus_write(26'd0, 32'hDEAD_BEEF, 4'hF);
        bus_read(26'd1, d); check("data_write_ignored", d, 32'h0000_000A);
        bus_write(26'd1, 32'h00, 4'hE);
        bus_read(26'd1, d); check("byteen0_gate", d, 32'h0000_000A);
        bus_read(26'd2, d); check("other_addr", d, 32'h0);
        bus_read(26'd1, d); check("cntrl_again", d, 32'h0000_000A);
        @(negedge clk); sel = 1'b0; rd = 1'b1; addr = 26'd0;
        @(negedge clk); rd = 1'b0;
        check("unselected_hold", rdata, 32'h0000_000A);

        // Enable in the middle of a right channel.
        bus_write(26'd1, 32'h00, 4'h1);
        bus_read(26'd1, d); check("disabled_cntrl", d, 32'h0000_0002);
        right_partial(6);
        bus_write(26'd1, 32'h08, 4'h1);
        right_partial(6);
        send_frame(16'h0F0F, 16'hF0F0, 16, 1'b0, 1'b0);
        send_frame(16'h1357, 16'h2468, 16, 1'b0, 1'b0);
        close_frame();
        bus_read(26'd1, d); check("midenable_cntrl", d, 32'h0000_0028);
        bus_read(26'd0, d); check("midenable_first", d, 32'h0F0F_F0F0);
        bus_read(26'd0, d); check("midenable_second", d, 32'h1357_2468);

        bus_read(26'd0, d); check("empty_read", d, 32'h0);
        bus_read(26'd1, d); check("empty_stays", d, 32'h0000_000A);

        // Overflow, then a read coinciding with a push while full.
        for (int i = 0; i < 17; i++)
            send_frame(16'h1100 + 16'(i), 16'h2200 + 16'(i), 16, 1'b0, 1'b0);
        close_frame();
        bus_read(26'd1, d); check("full_ovr_cntrl", d, 32'h0000_010D);
        send_frame(16'h3333, 16'h4444, 16, 1'b0, 1'b0);
        close_with_read(d); check("coincident_pop", d, 32'h1100_2200);
        bus_read(26'd1, d); check("coincident_fill", d, 32'h0000_010D);
        for (int i = 1; i < 16; i++) begin
            bus_read(26'd0, d);
            check($sformatf("readback_%0d", i), d, {16'h1100 + 16'(i), 16'h2200 + 16'(i)});
        end
        bus_read(26'd0, d); check("readback_last", d, 32'h3333_4444);
        bus_read(26'd1, d); check("drained_cntrl", d, 32'h0000_000E);
        bus_write(26'd1, 32'h0C, 4'h1);
        bus_read(26'd1, d); check("ovr_clear", d, 32'h0000_000A);

        // Reset mid-frame with entries queued.
        for (int i = 0; i < 3; i++)
            send_frame(16'h5500 + 16'(i), 16'h6600 + 16'(i), 16, 1'b0, 1'b0);
        close_frame();
        bus_read(26'd1, d); check("three_queued", d, 32'h0000_0038);
        left_partial(7);
        @(negedge clk); rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rdata_in_reset", rdata, 32'h0);
        rst = 1'b0;
        bus_read(26'd1, d); check("post_reset_cntrl", d, 32'h0000_0002);
        bus_write(26'd1, 32'h08, 4'h1);
        left_partial(5);
        right_partial(16);
        send_frame(16'hCAFE, 16'hF00D, 16, 1'b0, 1'b0);
        close_frame();
        bus_read(26'd1, d); check("resume_cntrl", d, 32'h0000_0018);
        bus_read(26'd0, d); check("resume_frame", d, 32'hCAFE_F00D);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/i2s_rx_bus_interface.md
I2S_RX_BUS_INTERFACE -- requirements
Module: i2s_rx_bus_interface

Interface
REQ-001 Parameter ADDR_SEL_BITS, default 4: number of bus address bits consumed by the slave decoder.
REQ-002 Parameter FIFO_DEPTH, default 16: sample-frame FIFO depth (power of 2).
REQ-003 i_Clk  in  1  system clock; single clock domain for all logic.
REQ-004 i_Reset  in  1  asynchronous, active-high reset.
REQ-005 i_SlaveSel  in  1  slave select; the bus access is ignored when low.
REQ-006 i_RegAddr  in  30-ADDR_SEL_BITS  register address: 0 = DATA, 1 = CNTRL; other addresses read 0, writes ignored.
REQ-007 i_AV_ByteEn  in  4  write byte enables.
REQ-008 i_AV_Read  in  1  read strobe, 1 cycle.
REQ-009 i_AV_Write  in  1  write strobe, 1 cycle.
REQ-010 o_AV_ReadData  out  32  registered read data.
REQ-011 i_AV_WriteData  in  32  write data.
REQ-012 o_AV_WaitRequest  out  1  held 0.
REQ-013 i_I2S0_SDOUT  in  1  serial data from the codec ADC.
REQ-014 i_I2S0_SCLK  in  1  bit clock; the codec is the master.
REQ-015 i_I2S0_LRCK  in  1  word select; 0 = left, 1 = right.

Function
REQ-016 SDOUT, SCLK and LRCK SHALL each pass through a 2-flop synchronizer; SCLK rising edges are detected from the synchronized value; i_Clk SHALL be at least 4x SCLK.
REQ-017 SDOUT and LRCK SHALL be sampled on each detected SCLK rising edge; a "transition edge" is an edge whose sampled LRCK differs from the value sampled at the previous edge.
REQ-018 States: IDLE, SYNC, RUN.
- IDLE while CNTRL.EN=0.
- EN 0->1: IDLE->SYNC.
- SYNC->RUN on the first LRCK 1->0 transition edge; no data is captured in SYNC.
- EN 1->0: any state->IDLE next cycle; the partial frame is discarded.
REQ-019 Bit counter cnt (5 bits, saturating at 16) SHALL clear on the edge after a transition edge.
- Each non-transition edge with cnt<16 shifts SDOUT into the current channel register MSB-first and increments cnt.
- A transition edge with cnt<16 shifts one final bit into the outgoing channel.
- Bits beyond 16 per channel are discarded; missing LSBs read as 0.
REQ-020 In RUN, each LRCK 1->0 transition edge SHALL push {left[15:0], right[15:0]} (left in [31:16]) into the FIFO one cycle after the edge, then clear both channel registers.
REQ-021 FIFO full at push: the frame is dropped and sticky CNTRL.OVR is set; FIFO contents are unchanged.
REQ-022 DATA read, FIFO non-empty: o_AV_ReadData = head entry on the cycle after i_AV_Read, and the head is popped.
REQ-023 DATA read, FIFO empty: returns 0, no pop, no error flag.
REQ-024 Same-cycle push and pop SHALL both occur, including when full; the count is unchanged.
REQ-025 CNTRL read layout:
- [0] FULL, [1] EMPTY, [2] OVR, [3] EN.
- [4+:log2(FIFO_DEPTH)+1] fill level.
- Other bits 0.
REQ-026 CNTRL write, only when i_AV_ByteEn[0]=1:
- bit3 -> EN.
- bit2=1 clears OVR.
- bit4=1 flushes the FIFO (self-clearing).
- A same-cycle flush overrides any push.
REQ-027 Writes to DATA SHALL be ignored; o_AV_ReadData SHALL hold its last value when no read is in progress.
REQ-028 Disabling (EN=0) SHALL NOT alter FIFO contents or OVR.

Reset
REQ-029 On i_Reset=1, immediately and asynchronously:
- o_AV_ReadData=0, EN=0, OVR=0.
- FIFO empty (CNTRL reads 0x00000002).
- State IDLE, cnt=0, channel registers 0, synchronizers 0.
REQ-030 Reset deassertion mid-frame SHALL restart in IDLE; no partial frame is ever pushed.

Verification
REQ-031 Enable; drive 16 SCLK/channel frames left=0xA5C3, right=0x1234 -> DATA read returns 0xA5C31234.
REQ-032 Enable mid-right-channel -> first FIFO entry is the first complete frame; the partial frame is absent.
REQ-033 32 SCLK/channel, left=0xBEEF plus 16 trailing ones, right=0x0001 plus zeros -> 0xBEEF0001.
REQ-034 Push FIFO_DEPTH+1 frames without reads -> FULL=1, OVR=1, fill=16, 16 frames read back in order; write CNTRL 0x0C -> OVR=0.
REQ-035 Read DATA with FIFO empty -> 0x00000000 and EMPTY stays 1; with FIFO full, a read coinciding with a push keeps fill=16.
REQ-036 Assert i_Reset mid-frame with 3 entries queued -> CNTRL=0x00000002 while in reset; after release and re-enable, capture resumes at the next left frame.
